// File: rtl/flash_array_ctrl.sv
// flash_array_ctrl: command sequencer for the 8x8 NAND flash array macro.
// Turns READ/PROGRAM/ERASE requests into timed select, WL, bias and sense controls.
module flash_array_ctrl #(
  parameter int T_SETUP = 4,
  parameter int T_PRE   = 8,
  parameter int T_SENSE = 8,
  parameter int T_PGM   = 64,
  parameter int T_ERS   = 256,
  parameter int CNT_W   = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic [1:0] SSL,
  output logic [1:0] GSL,
  output logic [3:0] WL0,
  output logic [3:0] WL1,
  output logic       SL,
  output logic       VBPW,
  output logic       sen1,
  output logic       sen2,
  output logic [3:0] out_en,
  input  logic [7:0] out,
  output logic [7:0] bl_out,
  output logic       bl_oe
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_PRE, S_SENSE, S_LATCH,
    S_CAPT, S_PGM, S_ERS, S_RECOV, S_DONE
  } state_e;

  typedef struct packed {
    logic [1:0] ssl;
    logic [1:0] gsl;
    logic [3:0] wl0;
    logic [3:0] wl1;
    logic       sl;
    logic       vbpw;
    logic       sen1;
    logic       sen2;
    logic [3:0] out_en;
    logic [7:0] bl_out;
    logic       bl_oe;
  } ctl_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_PG  = 2'b01;
  localparam logic [1:0] OP_ER  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q, op_d;
  logic [2:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  ctl_t             ctl_q;
  logic             accept;
  logic             cnt_zero;

  function automatic logic [CNT_W-1:0] load_of(state_e s);
    logic [CNT_W-1:0] v;
    unique case (s)
      S_SETUP, S_RECOV: v = CNT_W'(T_SETUP - 1);
      S_PRE:            v = CNT_W'(T_PRE - 1);
      S_SENSE:          v = CNT_W'(T_SENSE - 1);
      S_PGM:            v = CNT_W'(T_PGM - 1);
      S_ERS:            v = CNT_W'(T_ERS - 1);
      default:          v = '0;
    endcase
    return v;
  endfunction

  // Array controls as a pure function of the state being entered.
  function automatic ctl_t ctl_of(state_e s, logic [1:0] op,
                                  logic [2:0] a, logic [7:0] wd);
    ctl_t       c;
    logic [3:0] wl;
    logic       rd_ph;
    c     = '0;
    wl    = '0;
    rd_ph = s inside {S_SETUP, S_PRE, S_SENSE, S_LATCH, S_CAPT};
    unique case (1'b1)
      (op == OP_RD) && rd_ph: begin
        c.ssl[a[2]] = 1'b1;
        c.gsl[a[2]] = 1'b1;
        wl          = ~(4'b0001 << a[1:0]);
        c.sen1      = (s == S_PRE);
        c.sen2      = (s == S_SENSE);
        c.out_en    = {4{(s == S_LATCH) || (s == S_CAPT)}};
      end
      (op == OP_PG) && ((s == S_SETUP) || (s == S_PGM)): begin
        c.ssl[a[2]] = 1'b1;
        c.bl_oe     = 1'b1;
        c.bl_out    = wd;
        wl          = {4{s == S_PGM}};
      end
      (op == OP_ER) && (s == S_ERS): begin
        c.sl   = 1'b1;
        c.vbpw = 1'b1;
      end
      default: ;
    endcase
    if (a[2]) c.wl1 = wl;
    else      c.wl0 = wl;
    return c;
  endfunction

  assign accept   = cmd_valid && (state_q == S_IDLE);
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    op_d    = accept ? cmd_op    : op_q;
    addr_d  = accept ? cmd_addr  : addr_q;
    wdata_d = accept ? cmd_wdata : wdata_q;
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept) state_d = (cmd_op == OP_BAD) ? S_DONE : S_SETUP;
      S_SETUP:
        if (cnt_zero)
          state_d = (op_q == OP_RD) ? S_PRE :
                    (op_q == OP_PG) ? S_PGM : S_ERS;
      S_PRE:   if (cnt_zero) state_d = S_SENSE;
      S_SENSE: if (cnt_zero) state_d = S_LATCH;
      S_LATCH: state_d = S_CAPT;
      S_CAPT:  state_d = S_DONE;
      S_PGM:   if (cnt_zero) state_d = S_RECOV;
      S_ERS:   if (cnt_zero) state_d = S_RECOV;
      S_RECOV: if (cnt_zero) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ctl_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if (state_d != state_q) cnt_q <= load_of(state_d);
      else if (!cnt_zero)     cnt_q <= cnt_q - CNT_W'(1);
      ctl_q     <= ctl_of(state_d, op_d, addr_d, wdata_d);
      cmd_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_DONE);
      rsp_err   <= (state_d == S_DONE) && (op_d == OP_BAD);
      if (state_q == S_CAPT) rsp_rdata <= out;
    end
  end

  assign busy   = ~cmd_ready;
  assign SSL    = ctl_q.ssl;
  assign GSL    = ctl_q.gsl;
  assign WL0    = ctl_q.wl0;
  assign WL1    = ctl_q.wl1;
  assign SL     = ctl_q.sl;
  assign VBPW   = ctl_q.vbpw;
  assign sen1   = ctl_q.sen1;
  assign sen2   = ctl_q.sen2;
  assign out_en = ctl_q.out_en;
  assign bl_out = ctl_q.bl_out;
  assign bl_oe  = ctl_q.bl_oe;

endmodule

// File: tb/tb_flash_array_ctrl.sv
// tb_flash_array_ctrl: vector table, corner sequences and random commands
// checked cycle by cycle against a phase-schedule model and a cell-array model.
module tb_flash_array_ctrl;

  localparam int T_SETUP = 4;
  localparam int T_PRE   = 8;
  localparam int T_SENSE = 8;
  localparam int T_PGM   = 64;
  localparam int T_ERS   = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [2:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic [1:0] SSL, GSL;
  logic [3:0] WL0, WL1;
  logic       SL, VBPW, sen1, sen2;
  logic [3:0] out_en;
  logic [7:0] arr_out;
  logic [7:0] bl_out;
  logic       bl_oe;

  flash_array_ctrl dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),   .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err  (rsp_err),
    .busy     (busy),     .SSL      (SSL),
    .GSL      (GSL),      .WL0      (WL0),
    .WL1      (WL1),      .SL       (SL),
    .VBPW     (VBPW),     .sen1     (sen1),
    .sen2     (sen2),     .out_en   (out_en),
    .out      (arr_out),  .bl_out   (bl_out),
    .bl_oe    (bl_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ssl;
    logic [1:0] gsl;
    logic [3:0] wl0;
    logic [3:0] wl1;
    logic       sl;
    logic       vbpw;
    logic       sen1;
    logic       sen2;
    logic [3:0] oen;
    logic [7:0] blo;
    logic       bloe;
  } pins_t;

  typedef struct {
    logic [1:0] op;
    logic [2:0] a;
    logic [7:0] wd;
    int         lat;
    logic       err;
    logic [7:0] rd;
    bit         poke;
  } vec_t;

  logic [7:0] mem [8];
  logic [7:0] last_rd;
  int n_chk = 0;
  int n_pass = 0;

  // Cell array: selected block from SSL, selected WL is the one held low.
  always_comb begin
    logic       blk;
    logic [3:0] wlv;
    logic [1:0] idx;
    logic [7:0] d;
    arr_out = '0;
    blk = SSL[1];
    wlv = blk ? WL1 : WL0;
    idx = '0;
    for (int i = 0; i < 4; i++) if (!wlv[i]) idx = 2'(i);
    d = mem[{blk, idx}];
    for (int k = 0; k < 4; k++)
      if (out_en[k]) arr_out[2*k +: 2] = d[2*k +: 2];
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic pins_t pins_now();
    pins_t p;
    p.ssl = SSL;  p.gsl = GSL;  p.wl0 = WL0;  p.wl1 = WL1;
    p.sl = SL;    p.vbpw = VBPW; p.sen1 = sen1; p.sen2 = sen2;
    p.oen = out_en; p.blo = bl_out; p.bloe = bl_oe;
    return p;
  endfunction

  function automatic int lat_of(logic [1:0] op);
    case (op)
      2'b00:   return T_SETUP + T_PRE + T_SENSE + 3;
      2'b01:   return T_SETUP + T_PGM + T_SETUP + 1;
      2'b10:   return T_SETUP + T_ERS + T_SETUP + 1;
      default: return 1;
    endcase
  endfunction

  // Expected controls k cycles after the acceptance cycle.
  function automatic pins_t exp_pins(logic [1:0] op, logic [2:0] a,
                                     logic [7:0] wd, int k);
    pins_t      p;
    logic [3:0] wl;
    int         b;
    int         s;
    p  = '0;
    wl = '0;
    b  = int'(a[2]);
    s  = T_SETUP;
    case (op)
      2'b00: if (k <= s + T_PRE + T_SENSE + 2) begin
        p.ssl[b] = 1'b1;
        p.gsl[b] = 1'b1;
        wl = 4'hF;
        wl[a[1:0]] = 1'b0;
        p.sen1 = (k > s) && (k <= s + T_PRE);
        p.sen2 = (k > s + T_PRE) && (k <= s + T_PRE + T_SENSE);
        if (k > s + T_PRE + T_SENSE) p.oen = 4'hF;
      end
      2'b01: if (k <= s + T_PGM) begin
        p.ssl[b] = 1'b1;
        p.bloe = 1'b1;
        p.blo = wd;
        if (k > s) wl = 4'hF;
      end
      2'b10: if (k > s && k <= s + T_ERS) begin
        p.sl = 1'b1;
        p.vbpw = 1'b1;
      end
      default: ;
    endcase
    if (b == 1) p.wl1 = wl;
    else        p.wl0 = wl;
    return p;
  endfunction

  task automatic model_update(input logic [1:0] op, input logic [2:0] a,
                              input logic [7:0] wd);
    if (op == 2'b01) mem[a] = mem[a] & wd;
    if (op == 2'b10)
      for (int w = 0; w < 4; w++) mem[{a[2], 2'(w)}] = 8'hFF;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] a,
                         input logic [7:0] wd, input int exp_lat,
                         input logic exp_err, input logic [7:0] exp_rd,
                         input bit poke);
    int k;
    bit bad, got, seen;
    logic [$bits(pins_t)+1:0] act, exp, a_sv, e_sv;
    @(negedge clk);
    chk("ready_before", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = wd;
    k = 0; bad = 0; got = 0;
    a_sv = '0; e_sv = '0;
    while (!got && k < 400) begin
      @(negedge clk);
      k++;
      cmd_valid = poke && (k == T_SETUP + 100);
      if (cmd_valid) begin
        cmd_op = 2'b00;
        cmd_addr = 3'b000;
      end
      act = {cmd_ready, busy, pins_now()};
      exp = {1'b0, 1'b1, exp_pins(op, a, wd, k)};
      if (!bad) begin
        a_sv = act;
        e_sv = exp;
      end
      if (act !== exp) bad = 1;
      got = rsp_valid;
    end
    cmd_valid = 1'b0;
    chk("latency", 64'(got ? k : 0), 64'(exp_lat));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    if (op == 2'b00) begin
      chk("rdata", 64'(rsp_rdata), 64'(exp_rd));
      last_rd = exp_rd;
    end
    chk("pins", 64'(a_sv), 64'(e_sv));
    @(negedge clk);
    chk("after_rsp", {rsp_rdata, rsp_valid, cmd_ready}, {last_rd, 1'b0, 1'b1});
    if (poke) begin
      seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      chk("no_queue", 64'(seen), 64'd0);
    end
  endtask

  initial begin
    vec_t tbl[9];
    bit seen;
    logic [1:0] op;
    logic [2:0] a;
    logic [7:0] wd;

    tbl[0] = '{2'b00, 3'b110, 8'h00, 23,  1'b0, 8'hA5, 1'b0};
    tbl[1] = '{2'b01, 3'b000, 8'h3C, 73,  1'b0, 8'h00, 1'b0};
    tbl[2] = '{2'b00, 3'b000, 8'h00, 23,  1'b0, 8'h24, 1'b0};
    tbl[3] = '{2'b10, 3'b100, 8'h00, 265, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{2'b00, 3'b110, 8'h00, 23,  1'b0, 8'hFF, 1'b0};
    tbl[5] = '{2'b11, 3'b000, 8'h55, 1,   1'b1, 8'h00, 1'b0};
    tbl[6] = '{2'b00, 3'b000, 8'h00, 23,  1'b0, 8'h24, 1'b0};
    tbl[7] = '{2'b01, 3'b111, 8'h0F, 73,  1'b0, 8'h00, 1'b0};
    tbl[8] = '{2'b00, 3'b111, 8'h00, 23,  1'b0, 8'h0F, 1'b0};

    for (int i = 0; i < 8; i++) mem[i] = 8'hA5;
    last_rd = 8'h00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset", {cmd_ready, busy, rsp_valid, rsp_err, rsp_rdata, pins_now()},
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, pins_t'('0)});

    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].lat,
              tbl[i].err, tbl[i].rd, tbl[i].poke);
      model_update(tbl[i].op, tbl[i].a, tbl[i].wd);
    end

    // Reset in the middle of a program pulse.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_addr = 3'b010;
    cmd_wdata = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (T_SETUP + 10) @(negedge clk);
    chk("in_pgm", 64'({WL0, bl_oe}), 64'({4'hF, 1'b1}));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", {cmd_ready, rsp_valid, rsp_rdata, pins_now()},
        {1'b1, 1'b0, 8'h00, pins_t'('0)});
    rst = 1'b0;
    last_rd = 8'h00;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("rst_no_rsp", 64'(seen), 64'd0);
    run_cmd(2'b00, 3'b101, 8'h00, lat_of(2'b00), 1'b0, mem[5], 1'b0);

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 3'($urandom_range(0, 7));
      wd = 8'($urandom_range(0, 255));
      run_cmd(op, a, wd, lat_of(op), op == 2'b11, mem[a], 1'b0);
      model_update(op, a, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
